// File: rtl/cond_event_monitor.sv
// cond_event_monitor
// Multi-channel condition watcher. Each channel adds two unsigned operands
// without wrapping, compares the sum against a target under a selectable
// relation, and raises a one-cycle fire pulse on an edge or level trigger.
// Every channel has its own arming, one-shot/continuous mode, a timeout
// (the timeout value is shared) and a saturating hit counter.
module cond_event_monitor #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 16,
    parameter int TO_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] op_a,
    input  logic [NUM_CH*WIDTH-1:0] op_b,
    input  logic [NUM_CH*WIDTH-1:0] target,
    input  logic [NUM_CH*2-1:0]     mode,
    input  logic [NUM_CH-1:0]       lvl,
    input  logic [NUM_CH-1:0]       oneshot,
    input  logic [NUM_CH-1:0]       arm,
    input  logic [NUM_CH-1:0]       disarm,
    input  logic [TO_W-1:0]         timeout,
    input  logic                    clr_cnt,
    output logic [NUM_CH-1:0]       armed,
    output logic [NUM_CH-1:0]       fire,
    output logic [NUM_CH-1:0]       timed_out,
    output logic                    any_fire,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state    [NUM_CH];
    state_t            state_nx [NUM_CH];
    logic [TO_W-1:0]   timer    [NUM_CH];
    logic [TO_W-1:0]   timer_nx [NUM_CH];
    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [NUM_CH-1:0] cond_c;
    logic [NUM_CH-1:0] cond_q;
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] fire_nx;
    logic [NUM_CH-1:0] to_nx;

    // Sum is one bit wider than the operands so it never wraps; the target
    // is zero-extended and compared unsigned.
    function automatic logic relation(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] t,
                                      input logic [1:0]       m);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] tgt;
        logic           res;
        sum = {1'b0, a} + {1'b0, b};
        tgt = {1'b0, t};
        res = 1'b0;
        case (m)
            2'b00:   res = (sum == tgt);
            2'b01:   res = (sum != tgt);
            2'b10:   res = (sum >  tgt);
            default: res = (sum <  tgt);
        endcase
        return res;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Per-channel condition and trigger (edge compares against last cycle's condition).
    always_comb begin
        cond_c = '0;
        trig   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cond_c[i] = relation(op_a[i*WIDTH +: WIDTH], op_b[i*WIDTH +: WIDTH],
                                 target[i*WIDTH +: WIDTH], mode[i*2 +: 2]);
            trig[i]   = lvl[i] ? cond_c[i] : (cond_c[i] & ~cond_q[i]);
        end
    end

    // Next-state logic; priority within a cycle is disarm, trigger, timeout, arm.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nx[i] = state[i];
            timer_nx[i] = timer[i];
            fire_nx[i]  = 1'b0;
            to_nx[i]    = 1'b0;
            case (state[i])
                S_IDLE: begin
                    if (arm[i] && !disarm[i]) begin
                        state_nx[i] = S_WAIT;
                        timer_nx[i] = '0;
                    end
                end
                default: begin
                    if (disarm[i]) begin
                        state_nx[i] = S_IDLE;
                    end else if (trig[i]) begin
                        fire_nx[i]  = 1'b1;
                        timer_nx[i] = '0;
                        // A simultaneous arm re-arms a one-shot channel.
                        state_nx[i] = (oneshot[i] && !arm[i]) ? S_IDLE : S_WAIT;
                    end else if (timeout != '0 && timer[i] == timeout - TO_W'(1)) begin
                        to_nx[i]    = 1'b1;
                        state_nx[i] = S_IDLE;
                    end else if (arm[i]) begin
                        timer_nx[i] = '0;
                    end else begin
                        timer_nx[i] = timer[i] + TO_W'(1);
                    end
                end
            endcase
        end
    end

    // FSM state, timers, registered condition and output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= S_IDLE;
                timer[i] <= '0;
            end
            cond_q    <= '0;
            fire      <= '0;
            timed_out <= '0;
            any_fire  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nx[i];
                timer[i] <= timer_nx[i];
            end
            cond_q    <= cond_c;
            fire      <= fire_nx;
            timed_out <= to_nx;
            any_fire  <= |fire_nx;
        end
    end

    // Saturating hit counters; a clear coinciding with a fire leaves a count of one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_cnt)         cnt[i] <= fire_nx[i] ? CNT_W'(1) : '0;
                else if (fire_nx[i]) cnt[i] <= sat_inc(cnt[i]);
            end
        end
    end

    // Armed flag is a direct decode of the registered state.
    always_comb begin
        armed = '0;
        for (int i = 0; i < NUM_CH; i++) armed[i] = (state[i] == S_WAIT);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign hit_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule
